// File: rtl/multicycle_seq_if.sv
// Sequencer bus: CU control in, datapath strobes and PC out.
// master = sequencer side, slave = CU/datapath side.
interface multicycle_seq_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8
);
  logic              halt;
  logic              is_mem;
  logic              mem_ready;
  logic              PCSel;
  logic              RegWEn;
  logic              MemRW;
  logic              BrUn;
  logic [XLEN-1:0]   cmpA;
  logic [XLEN-1:0]   cmpB;
  logic [XLEN-1:0]   aluOut;
  logic [XLEN-1:0]   pc;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        stage;
  logic              BrEq;
  logic              BrLT;
  logic              ramEn;
  logic              ramRW;
  logic              regWe;
  logic [XLEN-1:0]   instret;

  modport master (
    input  halt, is_mem, mem_ready,
    input  PCSel, RegWEn, MemRW, BrUn,
    input  cmpA, cmpB, aluOut,
    output pc, addr, stage,
    output BrEq, BrLT,
    output ramEn, ramRW, regWe,
    output instret
  );

  modport slave (
    output halt, is_mem, mem_ready,
    output PCSel, RegWEn, MemRW, BrUn,
    output cmpA, cmpB, aluOut,
    input  pc, addr, stage,
    input  BrEq, BrLT,
    input  ramEn, ramRW, regWe,
    input  instret
  );
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle F/D/E/M/WB sequencer: PC, branch compare, RF/RAM enables.
// Define INSTRET_EN to build the retired-instruction counter.
module multicycle_seq #(
  parameter int                XLEN     = 32,
  parameter int                ADDR_W   = 8,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input logic               clk,
  input logic               rst,
  multicycle_seq_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } stage_e;

  stage_e          state_q;
  stage_e          state_d;
  logic            mem_q;
  logic            breq_q;
  logic            brlt_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic            retire;
  logic            lt_u;
  logic            lt_s;

  assign retire = (state_q == WRITEBACK);
  assign lt_u   = bus.cmpA < bus.cmpB;
  assign lt_s   = $signed(bus.cmpA) < $signed(bus.cmpB);

  // Jump targets are forced word-aligned.
  assign pc_d = bus.PCSel
              ? (bus.aluOut & ~XLEN'(3))
              : pc_q + XLEN'(PC_STEP);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     state_d = DECODE;
      DECODE:    state_d = bus.halt ? HALTED : EXECUTE;
      EXECUTE:   state_d = mem_q ? MEMORY : WRITEBACK;
      MEMORY:    if (bus.mem_ready) state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      HALTED:    state_d = HALTED;
      default:   state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      mem_q   <= 1'b0;
      breq_q  <= 1'b0;
      brlt_q  <= 1'b0;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        mem_q <= bus.is_mem;
      end
      if (state_q == EXECUTE) begin
        breq_q <= bus.cmpA == bus.cmpB;
        brlt_q <= bus.BrUn ? lt_u : lt_s;
      end
      if (retire) begin
        pc_q <= pc_d;
      end
    end
  end

`ifdef INSTRET_EN
  logic [XLEN-1:0] ret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q <= '0;
    end else if (retire) begin
      ret_q <= ret_q + XLEN'(1);
    end
  end

  assign bus.instret = ret_q;
`else
  assign bus.instret = '0;
`endif

  assign bus.pc    = pc_q;
  assign bus.addr  = pc_q[ADDR_W-1:0];
  assign bus.stage = state_q;
  assign bus.BrEq  = breq_q;
  assign bus.BrLT  = brlt_q;
  assign bus.ramEn = (state_q == MEMORY);
  assign bus.ramRW = (state_q == MEMORY) & bus.MemRW;
  assign bus.regWe = (state_q == WRITEBACK) & bus.RegWEn;

endmodule

// File: tb/tb_multicycle_seq.sv
// Scoreboard bench for multicycle_seq: random instructions vs a
// per-instruction reference model; retirements checked by a monitor.
module tb_multicycle_seq;

  localparam logic [31:0] RPC = 32'h10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_seq_if #(.XLEN(32), .ADDR_W(8)) bus ();

  multicycle_seq #(
    .XLEN(32), .ADDR_W(8), .RESET_PC(RPC), .PC_STEP(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    int          cyc;
    int          mcyc;
    logic        breq;
    logic        brlt;
    logic        regwe;
    logic [31:0] ret;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_pc     = RPC;
  logic [31:0] m_ret    = '0;
  bit          mon_en   = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] exp_ret(logic [31:0] n);
`ifdef INSTRET_EN
    return n;
`else
    return 32'h0;
`endif
  endfunction

  // Monitor: per-cycle enable rules, scoreboard pop on each WRITEBACK
  initial begin
    int   cyc;
    int   mc;
    exp_t e;
    cyc = 0;
    mc  = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        cyc = 0;
        mc  = 0;
        continue;
      end
      if (bus.stage == 3'd0) begin
        cyc = 1;
        mc  = 0;
      end else begin
        cyc++;
      end
      if (bus.stage == 3'd3) mc++;
      chk("ramEn", bus.ramEn, bus.stage == 3'd3);
      chk("ramRW", bus.ramRW, (bus.stage == 3'd3) && bus.MemRW);
      chk("regWe", bus.regWe, (bus.stage == 3'd4) && bus.RegWEn);
      chk("addr", bus.addr, bus.pc[7:0]);
      if (bus.stage == 3'd4) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire: got unexpected retirement want none");
        end else begin
          e = sbq.pop_front();
          chk("wb_pc", bus.pc, e.pc);
          chk("wb_cycles", 64'(cyc), 64'(e.cyc));
          chk("mem_cycles", 64'(mc), 64'(e.mcyc));
          chk("BrEq", bus.BrEq, e.breq);
          chk("BrLT", bus.BrLT, e.brlt);
          chk("wb_regWe", bus.regWe, e.regwe);
          chk("instret", bus.instret, e.ret);
        end
      end
    end
  end

  // Issue one instruction from a FETCH negedge; returns at next FETCH
  // (or at HALTED for a halt instruction).
  task automatic run(input bit hlt, input bit ism, input int stall,
                     input bit psel, input bit rwe, input bit mrw,
                     input bit brun, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] alu);
    exp_t e;
    int   mcnt;
    bit   done;
    bus.halt   = hlt;
    bus.is_mem = ism;
    bus.PCSel  = psel;
    bus.RegWEn = rwe;
    bus.MemRW  = mrw;
    bus.BrUn   = brun;
    bus.cmpA   = a;
    bus.cmpB   = b;
    bus.aluOut = alu;
    if (!hlt) begin
      e.pc    = m_pc;
      e.cyc   = ism ? 5 + stall : 4;
      e.mcyc  = ism ? stall + 1 : 0;
      e.breq  = (a == b);
      e.brlt  = brun ? (a < b) : (int'(a) < int'(b));
      e.regwe = rwe;
      e.ret   = exp_ret(m_ret);
      sbq.push_back(e);
      m_pc  = psel ? (alu & 32'hFFFF_FFFC) : m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
    end
    mcnt = 0;
    done = 1'b0;
    for (int n = 0; n < 64 && !done; n++) begin
      @(negedge clk);
      if (bus.stage == 3'd3) begin
        bus.mem_ready = (mcnt >= stall);
        mcnt++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      if (bus.stage == 3'd0) done = 1'b1;
      if (hlt && bus.stage == 3'd5) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout: got stage %0d want end of instruction",
               bus.stage);
    end
  endtask

  task automatic run_rand();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    run(1'b0, 1'($urandom), $urandom_range(0, 4),
        $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
        1'($urandom), a, b, $urandom);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_stage"}, bus.stage, 3'd0);
    chk({tag, "_pc"}, bus.pc, RPC);
    chk({tag, "_BrEq"}, bus.BrEq, 1'b0);
    chk({tag, "_BrLT"}, bus.BrLT, 1'b0);
    chk({tag, "_instret"}, bus.instret, 32'h0);
    chk({tag, "_ramEn"}, bus.ramEn, 1'b0);
    chk({tag, "_ramRW"}, bus.ramRW, 1'b0);
    chk({tag, "_regWe"}, bus.regWe, 1'b0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst    = 1'b1;
    m_pc   = RPC;
    m_ret  = '0;
    mon_en = 1'b1;
  endtask

  initial begin
    bit ok;
    bus.halt      = 1'b0;
    bus.is_mem    = 1'b0;
    bus.mem_ready = 1'b0;
    bus.PCSel     = 1'b0;
    bus.RegWEn    = 1'b1;
    bus.MemRW     = 1'b1;
    bus.BrUn      = 1'b0;
    bus.cmpA      = '0;
    bus.cmpB      = '0;
    bus.aluOut    = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_state("reset");
    release_rst();

    // Plain ALU op then a load with three stall cycles
    run(0, 0, 0, 0, 1, 0, 0, 32'd7, 32'd9, 32'h55);
    chk("pc_after_alu", bus.pc, 32'h14);
    run(0, 1, 3, 0, 1, 0, 0, 32'd1, 32'd2, 32'h0);
    chk("pc_after_load", bus.pc, 32'h18);

    // Branch comparator corners
    run(0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    run(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'd1, 32'h0);
    run(0, 1, 1, 0, 0, 1, 0, 32'd5, 32'd5, 32'h0);

    // Jump alignment and PC wrap
    run(0, 0, 0, 1, 1, 0, 0, 32'd0, 32'd0, 32'h103);
    chk("pc_jump", bus.pc, 32'h100);
    run(0, 0, 0, 1, 0, 0, 0, 32'd0, 32'd0, 32'hFFFF_FFFE);
    chk("pc_top", bus.pc, 32'hFFFF_FFFC);
    run(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'h0);
    chk("pc_wrap", bus.pc, 32'h0);

    for (int i = 0; i < 40; i++) run_rand();

    // Halt beats is_mem; HALTED must stay inert
    run(1, 1, 0, 1, 1, 1, 0, 32'd0, 32'd0, 32'h40);
    chk("halt_stage", bus.stage, 3'd5);
    for (int i = 0; i < 20; i++) begin
      bus.mem_ready = 1'($urandom);
      @(negedge clk);
      #1;
      chk("halted_stage", bus.stage, 3'd5);
      chk("halted_pc", bus.pc, m_pc);
      chk("halted_ramEn", bus.ramEn, 1'b0);
      chk("halted_ramRW", bus.ramRW, 1'b0);
      chk("halted_regWe", bus.regWe, 1'b0);
    end
    mon_en = 1'b0;
    sbq.delete();
    rst = 1'b0;
    #1;
    check_reset_state("halt_reset");
    release_rst();

    // Three retirements, then reset in the middle of a stalled access
    for (int i = 0; i < 3; i++) run_rand();
    bus.halt      = 1'b0;
    bus.is_mem    = 1'b1;
    bus.MemRW     = 1'b1;
    bus.PCSel     = 1'b0;
    bus.cmpA      = 32'd3;
    bus.cmpB      = 32'd3;
    bus.mem_ready = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 16 && !ok; n++) begin
      @(negedge clk);
      bus.mem_ready = 1'b0;
      if (bus.stage == 3'd3) ok = 1'b1;
    end
    chk("reach_memory", ok, 1'b1);
    repeat (2) @(negedge clk);
    chk("stall_stage", bus.stage, 3'd3);
    chk("stall_ramEn", bus.ramEn, 1'b1);
    chk("stall_BrEq", bus.BrEq, 1'b1);
    chk("stall_instret", bus.instret, exp_ret(32'd3));
    mon_en = 1'b0;
    sbq.delete();
    rst = 1'b0;
    #1;
    check_reset_state("mem_reset");
    release_rst();
    run_rand();
    run_rand();

    mon_en = 1'b0;
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_seq.md
# multicycle_seq

Parametrised multi-cycle instruction sequencer for the RISC-V core: owns the program counter, an explicit fetch/decode/execute/memory/writeback state machine, the branch comparator, and write-enable gating for the register file and RAM. It replaces the free-running five-cycle counter in the CPU top with a stage FSM that skips the memory stage for non-memory instructions, stalls on a RAM ready handshake, and supports halt. It sits between the CU (control decode) and the ROM/Regfile/RAM/ALU datapath.

## Interface
- XLEN, 32, data and PC width
- ADDR_W, 8, instruction address width driven to ROM (low bits of PC)
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment
---
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- halt  in  1  instruction is a halt (from CU), sampled in DECODE
- is_mem  in  1  instruction uses RAM (load/store), sampled in DECODE
- mem_ready  in  1  RAM access complete
- PCSel  in  1  take ALU result as next PC (jump / taken branch)
- RegWEn  in  1  CU register write request
- MemRW  in  1  CU memory direction (1 = write)
- BrUn  in  1  unsigned branch compare
- cmpA, cmpB  in  XLEN  branch compare operands (regOut1, regOut2)
- aluOut  in  XLEN  ALU result / branch target
- pc  out  XLEN  current PC
- addr  out  ADDR_W  ROM address, pc[ADDR_W-1:0]
- stage  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALTED=5
- BrEq, BrLT  out  1  registered comparator results
- ramEn  out  1  RAM enable, high only in MEMORY
- ramRW  out  1  MemRW gated by ramEn
- regWe  out  1  RegWEn gated, high only in WRITEBACK
- instret  out  XLEN  retired instruction count (see Configuration)

## Operation
- FETCH -> DECODE unconditionally; ROM reads addr.
- DECODE: halt=1 -> HALTED (halt wins over is_mem); else latch is_mem, -> EXECUTE.
- EXECUTE: BrEq <= (cmpA == cmpB); BrLT <= BrUn ? unsigned cmpA<cmpB : signed cmpA<cmpB (two's complement). -> MEMORY if latched is_mem, else WRITEBACK.
- MEMORY: ramEn=1, ramRW=MemRW; stay while mem_ready=0; -> WRITEBACK on mem_ready=1.
- WRITEBACK: regWe=RegWEn; pc <= PCSel ? {aluOut[XLEN-1:2],2'b00} : pc+PC_STEP (mod 2^XLEN, wraps silently); -> FETCH.
- HALTED: absorbing; all enables 0, pc frozen; left only by reset.
- BrEq/BrLT hold between EXECUTE states.

## Timing
- Reset (rst=0, any time, incl. mid-MEMORY): immediately stage=FETCH, pc=RESET_PC, BrEq=BrLT=0, instret=0; ramEn, ramRW, regWe=0 combinationally from stage.
- First FETCH is the first rising edge after rst deasserts.
- Non-memory instruction: 4 cycles; memory instruction: 5 + N cycles for N cycles of mem_ready=0.
- mem_ready is only sampled in MEMORY; ignored elsewhere.
- pc changes only on the WRITEBACK->FETCH edge; addr is stable for FETCH through WRITEBACK.
- ramEn, ramRW, regWe are Moore outputs decoded from stage (RegWEn/MemRW pass through combinationally while enabled).

## Configuration
- INSTRET_EN defined: instret increments by 1 on every WRITEBACK->FETCH edge, wraps at 2^XLEN, cleared by reset.
- INSTRET_EN undefined: counter not built; instret tied to 0.

## Test plan
- Reset RESET_PC=0x10, release, is_mem=0, PCSel=0 -> stage 0,1,2,4,0; pc=0x14 after cycle 4; regWe high only in stage 4.
- Load: is_mem=1, mem_ready low 3 cycles -> 3 extra MEMORY cycles with ramEn=1, total 8 cycles; pc advances once.
- Branch compare: cmpA=0xFFFFFFFF, cmpB=1; BrUn=0 -> BrLT=1, BrEq=0; BrUn=1 -> BrLT=0; cmpA=cmpB=5 -> BrEq=1.
- PCSel=1, aluOut=0x103 -> pc=0x100; pc=0xFFFFFFFC, PCSel=0 -> pc=0x0.
- halt=1 in DECODE -> stage=5, pc frozen, enables 0 for 20 cycles; rst pulse -> FETCH, pc=RESET_PC.
- rst asserted mid-MEMORY with mem_ready=0 -> ramEn drops same cycle, stage=FETCH; with INSTRET_EN, 3 retired instructions then reset -> instret 3 -> 0.
